// File: rtl/pipeline_control.sv
// Stage-sequencing controller for the 5-stage pipeline: per-stage enables/flushes plus drain/halt FSM.
// Optional stall-cycle counter is built when PIPELINE_CONTROL_PERF_EN is defined.
module pipeline_control (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_use_stall,
   input  logic       branch_taken,
   input  logic       halt_req,
   input  logic       imem_ready,
   input  logic       M_is_mem,
   input  logic       dmem_ready,
   output logic       F_en,
   output logic       D_en,
   output logic       E_en,
   output logic       M_en,
   output logic       W_en,
   output logic       D_flush,
   output logic       E_flush,
   output logic       W_flush,
   output logic       halted,
   output logic [1:0] state
`ifdef PIPELINE_CONTROL_PERF_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t     cur_state, nxt_state;
   logic [1:0] drain_cnt, nxt_cnt;
   logic       mem_wait;

   assign mem_wait = M_is_mem & ~dmem_ready;
   assign state    = cur_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= ST_RUN;
         drain_cnt <= '0;
      end else begin
         cur_state <= nxt_state;
         drain_cnt <= nxt_cnt;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      nxt_cnt   = drain_cnt;
      case (cur_state)
         ST_RUN: begin
            // halt only accepted when nothing above it in priority is active
            if (!mem_wait && !branch_taken && !load_use_stall && halt_req) begin
               nxt_state = ST_DRAIN;
               nxt_cnt   = 2'd3;
            end
         end
         ST_DRAIN: begin
            if (mem_wait) begin
               nxt_cnt = drain_cnt;
            end else if (branch_taken) begin
               nxt_state = ST_RUN;
               nxt_cnt   = '0;
            end else if (drain_cnt <= 2'd1) begin
               nxt_state = ST_HALTED;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = drain_cnt - 2'd1;
            end
         end
         ST_HALTED: begin
            nxt_state = ST_HALTED;
            nxt_cnt   = '0;
         end
         default: begin
            nxt_state = ST_RUN;
            nxt_cnt   = '0;
         end
      endcase
   end

   always_comb begin
      F_en    = 1'b1;
      D_en    = 1'b1;
      E_en    = 1'b1;
      M_en    = 1'b1;
      W_en    = 1'b1;
      D_flush = 1'b0;
      E_flush = 1'b0;
      W_flush = 1'b0;
      halted  = 1'b0;
      if (reset) begin
         F_en    = 1'b0;
         D_en    = 1'b0;
         E_en    = 1'b0;
         M_en    = 1'b0;
         W_en    = 1'b0;
         D_flush = 1'b1;
         E_flush = 1'b1;
         W_flush = 1'b1;
      end else begin
         case (cur_state)
            ST_RUN: begin
               if (mem_wait) begin
                  F_en    = 1'b0;
                  D_en    = 1'b0;
                  E_en    = 1'b0;
                  M_en    = 1'b0;
                  W_flush = 1'b1;
               end else if (branch_taken) begin
                  D_flush = 1'b1;
                  E_flush = 1'b1;
               end else if (load_use_stall) begin
                  F_en    = 1'b0;
                  D_en    = 1'b0;
                  E_flush = 1'b1;
               end else if (!imem_ready) begin
                  F_en    = 1'b0;
                  D_flush = 1'b1;
               end
            end
            ST_DRAIN: begin
               // fetch stays off and IF/ID keeps bubbles unless an older branch squashes the halt
               if (mem_wait) begin
                  F_en    = 1'b0;
                  D_en    = 1'b0;
                  E_en    = 1'b0;
                  M_en    = 1'b0;
                  D_flush = 1'b1;
                  W_flush = 1'b1;
               end else if (branch_taken) begin
                  D_flush = 1'b1;
                  E_flush = 1'b1;
               end else begin
                  F_en    = 1'b0;
                  D_flush = 1'b1;
               end
            end
            default: begin
               F_en   = 1'b0;
               D_en   = 1'b0;
               E_en   = 1'b0;
               M_en   = 1'b0;
               W_en   = 1'b0;
               halted = 1'b1;
            end
         endcase
      end
   end

`ifdef PIPELINE_CONTROL_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (cur_state != ST_HALTED && (!F_en || mem_wait)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
